// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
//   Bundle of every handshake and data signal between the ALU issue stage and
//   its neighbours: the instruction source, the ALU writeback path, and the
//   ALU operand consumer.
//
//   Signals:
//     IN_VALID / IN_READY / IN_INSTR : instruction word handshake
//                                      ([15:12] op, [11:9] rd, [8:6] ra,
//                                       [5:3] rb, [2] sel, [1:0] ignored)
//     WB_EN / WB_ADDR / WB_DATA      : register-file writeback strobe
//     OUT_VALID / OUT_READY          : operand handshake towards the ALU
//     A, B, INST, SEL, OUT_DEST      : registered operand payload
//
//   Modports:
//     slave  : the issue stage itself
//     master : the environment (instruction source, ALU, writeback)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if;
  logic               IN_VALID;
  logic               IN_READY;
  logic [15:0]        IN_INSTR;

  logic               WB_EN;
  logic [2:0]         WB_ADDR;
  logic [31:0]        WB_DATA;

  logic               OUT_VALID;
  logic               OUT_READY;
  logic signed [31:0] A;
  logic signed [31:0] B;
  logic [3:0]         INST;
  logic               SEL;
  logic [2:0]         OUT_DEST;

  modport slave (
    input  IN_VALID, IN_INSTR, WB_EN, WB_ADDR, WB_DATA, OUT_READY,
    output IN_READY, OUT_VALID, A, B, INST, SEL, OUT_DEST
  );

  modport master (
    output IN_VALID, IN_INSTR, WB_EN, WB_ADDR, WB_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, A, B, INST, SEL, OUT_DEST
  );
endinterface : alu_issue_stage_if

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//   Operand-issue stage in front of a 32-bit combinational ALU. Accepts one
//   16-bit instruction per cycle, reads ra/rb from an 8-entry register file
//   (R0 hard-wired to zero), and presents registered A/B/INST/SEL/OUT_DEST to
//   the ALU. Results come back through the WB_* port. A per-register pending
//   bit (scoreboard) blocks issue of any instruction whose ra or rb still has
//   a result in flight.
//
//   Ports:
//     CLK  : rising-edge clock
//     RST  : asynchronous active-high reset
//     bus  : alu_issue_stage_if.slave (instruction, writeback, operand ports)
//
//   Parameters:
//     REG_RESET : reset value of R1..R7
//
//   Build option:
//     ALU_ISSUE_BYPASS_EN : when defined, a writeback in the same cycle as the
//       read forwards WB_DATA into the operand and masks that register's
//       pending bit, so a dependent instruction issues in the writeback cycle.
//       When undefined, the dependent instruction issues one cycle later.
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  alu_issue_stage_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [3:0] op_f;
  logic [2:0] rd_f;
  logic [2:0] ra_f;
  logic [2:0] rb_f;
  logic       sel_f;
  logic       unused_rsvd;

  assign op_f        = bus.IN_INSTR[15:12];
  assign rd_f        = bus.IN_INSTR[11:9];
  assign ra_f        = bus.IN_INSTR[8:6];
  assign rb_f        = bus.IN_INSTR[5:3];
  assign sel_f       = bus.IN_INSTR[2];
  assign unused_rsvd = ^bus.IN_INSTR[1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [8];
  logic [31:0] regs_d [8];
  logic [7:0]  pend_q, pend_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  inst_q, inst_d;
  logic        sel_q, sel_d;
  logic [2:0]  dest_q, dest_d;

  // ---------------------------------------------------------------------------
  // Operand read and hazard detection
  // ---------------------------------------------------------------------------
  logic [31:0] opa_val, opb_val;
  logic        blk_a, blk_b;
  logic        haz;
  logic        in_ready;
  logic        accept;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    opa_val = regs_q[ra_f];
    opb_val = regs_q[rb_f];
    blk_a   = pend_q[ra_f];
    blk_b   = pend_q[rb_f];
`ifdef ALU_ISSUE_BYPASS_EN
    // R0 is excluded: a write to R0 is discarded, so it must not forward.
    if (bus.WB_EN && (bus.WB_ADDR == ra_f) && (ra_f != 3'd0)) begin
      opa_val = bus.WB_DATA;
      blk_a   = 1'b0;
    end
    if (bus.WB_EN && (bus.WB_ADDR == rb_f) && (rb_f != 3'd0)) begin
      opb_val = bus.WB_DATA;
      blk_b   = 1'b0;
    end
`endif
    // Both sources are always checked, even for opcodes that ignore B.
    haz = blk_a | blk_b;
  end

  assign in_ready = !haz && (!out_valid_q || bus.OUT_READY);
  assign accept   = bus.IN_VALID && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d      = regs_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    inst_d      = inst_q;
    sel_d       = sel_q;
    dest_d      = dest_q;

    // Register file write; R0 stays zero.
    if (bus.WB_EN && (bus.WB_ADDR != 3'd0)) begin
      regs_d[bus.WB_ADDR] = bus.WB_DATA;
    end

    // Scoreboard: clear first, then set, so a same-cycle set of the same
    // register wins.
    if (bus.WB_EN) begin
      pend_d[bus.WB_ADDR] = 1'b0;
    end
    if (accept && (rd_f != 3'd0)) begin
      pend_d[rd_f] = 1'b1;
    end
    pend_d[0] = 1'b0;

    // Output register: load on accept, clear valid on drain, otherwise hold.
    if (accept) begin
      out_valid_d = 1'b1;
      a_d         = opa_val;
      b_d         = opb_val;
      inst_d      = op_f;
      sel_d       = sel_f;
      dest_d      = rd_f;
    end else if (bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: the register file is reset on purpose: R1..R7 must come up as
  // REG_RESET, and reset must restore them mid-operation, so it cannot be a
  // plain RAM without reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= (i == 0) ? 32'h0 : REG_RESET;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      inst_q      <= '0;
      sel_q       <= 1'b0;
      dest_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      inst_q      <= inst_d;
      sel_q       <= sel_d;
      dest_q      <= dest_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.INST      = inst_q;
  assign bus.SEL       = sel_q;
  assign bus.OUT_DEST  = dest_q;

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//   Self-checking bench for alu_issue_stage. A behavioural model (register
//   array, pending flags, a queue holding the op presented to the ALU) is
//   compared against the DUT every cycle; directed sequences add literal
//   expectations, then a randomized phase acts as instruction source and ALU.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam logic [31:0] RR = 32'h1234_5678;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.REG_RESET(RR)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------------------
  // Scorekeeping
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  inst;
    logic        sel;
    logic [2:0]  dest;
  } op_t;

  logic [31:0] m_regs [8];
  bit          m_pend [8];
  op_t         exp_q[$];   // op currently presented to the ALU (0 or 1 entry)
  op_t         m_last;     // payload left on the outputs after a drain
  logic [2:0]  alu_q[$];   // destinations waiting for a writeback

  function automatic bit wb_hits(input logic [2:0] r);
    return bus.WB_EN && (bus.WB_ADDR == r) && (r != 3'd0);
  endfunction

  function automatic bit m_blocked(input logic [2:0] r);
    return m_pend[r] && !(BYP && wb_hits(r));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] r);
    if (r == 3'd0)            return 32'h0;
    if (BYP && wb_hits(r))    return bus.WB_DATA;
    return m_regs[r];
  endfunction

  function automatic bit m_ready();
    logic [2:0] ra, rb;
    ra = bus.IN_INSTR[8:6];
    rb = bus.IN_INSTR[5:3];
    return !(m_blocked(ra) || m_blocked(rb)) &&
           ((exp_q.size() == 0) || bus.OUT_READY);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = (i == 0) ? 32'h0 : RR;
      m_pend[i] = 1'b0;
    end
    exp_q.delete();
    alu_q.delete();
    m_last = '{a: 32'h0, b: 32'h0, inst: 4'h0, sel: 1'b0, dest: 3'h0};
  endtask

  // Apply the effect of the coming rising edge to the model.
  task automatic model_update();
    bit  acc, cons;
    op_t nop;
    acc  = bus.IN_VALID && m_ready();
    cons = (exp_q.size() != 0) && bus.OUT_READY;
    nop.a    = m_read(bus.IN_INSTR[8:6]);
    nop.b    = m_read(bus.IN_INSTR[5:3]);
    nop.inst = bus.IN_INSTR[15:12];
    nop.sel  = bus.IN_INSTR[2];
    nop.dest = bus.IN_INSTR[11:9];
    if (cons) begin
      m_last = exp_q.pop_front();
      if (m_last.dest != 3'd0) alu_q.push_back(m_last.dest);
    end
    if (acc) exp_q.push_back(nop);
    if (bus.WB_EN) begin
      m_pend[bus.WB_ADDR] = 1'b0;
      if (bus.WB_ADDR != 3'd0) m_regs[bus.WB_ADDR] = bus.WB_DATA;
    end
    if (acc && nop.dest != 3'd0) m_pend[nop.dest] = 1'b1;
  endtask

  task automatic compare();
    op_t cur;
    cur = (exp_q.size() != 0) ? exp_q[0] : m_last;
    check("in_ready",  bus.IN_READY,  m_ready());
    check("out_valid", bus.OUT_VALID, exp_q.size() != 0);
    check("a",         bus.A,         cur.a);
    check("b",         bus.B,         cur.b);
    check("inst",      bus.INST,      cur.inst);
    check("sel",       bus.SEL,       cur.sel);
    check("out_dest",  bus.OUT_DEST,  cur.dest);
  endtask

  // Inputs are driven just after a falling edge; step checks, advances the
  // model across the next rising edge, and returns at the following falling edge.
  task automatic step();
    #1;
    compare();
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [15:0] instr, input bit wen,
                       input logic [2:0] waddr, input logic [31:0] wdata,
                       input bit ordy);
    bus.IN_VALID  = v;
    bus.IN_INSTR  = instr;
    bus.WB_EN     = wen;
    bus.WB_ADDR   = waddr;
    bus.WB_DATA   = wdata;
    bus.OUT_READY = ordy;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic sel);
    return {op, rd, ra, rb, sel, 2'b00};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    drive(0, 16'h0, 0, 3'd0, 32'h0, 1);
    model_reset();
    #3;
    check("rst_out_valid", bus.OUT_VALID, 1'b0);
    check("rst_a",         bus.A,         32'h0);
    check("rst_dest",      bus.OUT_DEST,  3'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", bus.IN_READY, 1'b1);

    // Reset and R0
    drive(1, mk(4'h0, 3'd1, 3'd0, 3'd0, 0), 0, 3'd0, 32'h0, 1); step();
    check("r0_valid", bus.OUT_VALID, 1'b1);
    check("r0_a",     bus.A,         32'h0);
    check("r0_b",     bus.B,         32'h0);
    check("r0_inst",  bus.INST,      4'h0);
    check("r0_dest",  bus.OUT_DEST,  3'd1);
    drive(0, 16'h0, 1, 3'd0, 32'hDEAD_BEEF, 1); step();
    drive(1, mk(4'h0, 3'd0, 3'd0, 3'd0, 0), 0, 3'd0, 32'h0, 1); step();
    check("r0_read", bus.A, 32'h0);

    // Writeback then read; also settle R1 and R6 to known values
    drive(0, 16'h0, 1, 3'd2, 32'h0000_0005, 1); step();
    drive(0, 16'h0, 1, 3'd3, 32'hFFFF_FFFD, 1); step();
    drive(1, mk(4'b1000, 3'd6, 3'd2, 3'd3, 1), 0, 3'd0, 32'h0, 1); step();
    check("wb_a",    bus.A,    32'h0000_0005);
    check("wb_b",    bus.B,    32'hFFFF_FFFD);
    check("wb_inst", bus.INST, 4'b1000);
    check("wb_sel",  bus.SEL,  1'b1);
    drive(0, 16'h0, 1, 3'd1, 32'h11, 1); step();
    drive(0, 16'h0, 1, 3'd6, 32'h66, 1); step();

    // RAW stall
    drive(1, mk(4'h1, 3'd4, 3'd0, 3'd0, 0), 0, 3'd0, 32'h0, 1); step();
    drive(1, mk(4'h2, 3'd7, 3'd4, 3'd0, 0), 0, 3'd0, 32'h0, 1);
    #1 check("raw_stall", bus.IN_READY, 1'b0);
    step();
    drive(1, mk(4'h2, 3'd7, 3'd4, 3'd0, 0), 1, 3'd4, 32'h10, 1);
    #1 check("raw_wb_cycle_ready", bus.IN_READY, BYP);
    step();
    if (!BYP) begin
      drive(1, mk(4'h2, 3'd7, 3'd4, 3'd0, 0), 0, 3'd0, 32'h0, 1);
      #1 check("raw_after_wb_ready", bus.IN_READY, 1'b1);
      step();
    end
    check("raw_a",    bus.A,    32'h10);
    check("raw_inst", bus.INST, 4'h2);
    drive(0, 16'h0, 1, 3'd7, 32'h77, 1); step();

    // Backpressure
    drive(1, mk(4'h3, 3'd0, 3'd1, 3'd2, 0), 0, 3'd0, 32'h0, 1); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(4'h4, 3'd0, 3'd2, 3'd1, 1), 0, 3'd0, 32'h0, 0);
      #1 check("bp_ready", bus.IN_READY, 1'b0);
      step();
      check("bp_a",    bus.A,    32'h11);
      check("bp_inst", bus.INST, 4'h3);
    end
    drive(1, mk(4'h4, 3'd0, 3'd2, 3'd1, 1), 0, 3'd0, 32'h0, 1);
    #1 check("bp_release_ready", bus.IN_READY, 1'b1);
    step();
    check("bp_next_valid", bus.OUT_VALID, 1'b1);
    check("bp_next_a",     bus.A,         32'h5);
    check("bp_next_b",     bus.B,         32'h11);
    check("bp_next_inst",  bus.INST,      4'h4);

    // Simultaneous set and clear of R5
    drive(1, mk(4'h5, 3'd5, 3'd0, 3'd0, 0), 1, 3'd5, 32'h55, 1); step();
    drive(1, mk(4'h6, 3'd0, 3'd5, 3'd0, 0), 0, 3'd0, 32'h0, 1);
    #1 check("setclr_stall", bus.IN_READY, 1'b0);
    step();
    drive(0, 16'h0, 1, 3'd5, 32'h5A, 1); step();
    drive(0, 16'h0, 0, 3'd0, 32'h0, 1); step();

    // Async reset mid-stall
    drive(1, mk(4'h7, 3'd3, 3'd2, 3'd1, 0), 0, 3'd0, 32'h0, 0); step();
    drive(1, mk(4'h8, 3'd0, 3'd3, 3'd0, 0), 0, 3'd0, 32'h0, 0); step();
    #2 rst = 1'b1;
    #1 check("arst_valid", bus.OUT_VALID, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, mk(4'h9, 3'd0, 3'd2, 3'd3, 0), 0, 3'd0, 32'h0, 1); step();
    check("arst_reg_a", bus.A, RR);
    check("arst_reg_b", bus.B, RR);

    // Randomized traffic: bench acts as instruction source and as the ALU
    for (int c = 0; c < 3000; c++) begin
      logic        wen;
      logic [2:0]  waddr;
      wen   = 1'b0;
      waddr = 3'd0;
      if (alu_q.size() != 0 && ($urandom % 2 == 0)) begin
        wen   = 1'b1;
        waddr = alu_q.pop_front();
      end else if ($urandom % 8 == 0) begin
        wen   = 1'b1;
        waddr = 3'($urandom_range(0, 7));
      end
      drive($urandom % 4 != 0,
            mk(4'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom)),
            wen, waddr, $urandom, $urandom % 4 != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_issue_stage

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue stage directly upstream of the 32-bit combinational ALU. Accepts 16-bit instruction words over a valid/ready handshake and reads two source operands from an 8-entry register file. Presents registered `A`, `B`, `INST`, `SEL` to the ALU and accepts ALU results back through a writeback port. A per-register scoreboard stalls issue on read-after-write hazards until the result is written back.

## Interface
Parameters:
- `REG_RESET`, 32'h0000_0000: value loaded into R1–R7 on reset.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `IN_VALID` in 1: instruction word valid.
- `IN_READY` out 1: stage can accept this cycle.
- `IN_INSTR` in 16: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2] sel, [1:0] reserved, ignored.
- `WB_EN` in 1: writeback strobe.
- `WB_ADDR` in 3: writeback register.
- `WB_DATA` in 32: writeback value.
- `OUT_VALID` out 1: ALU operands valid.
- `OUT_READY` in 1: downstream consumes the operands.
- `A`, `B` out 32 each: signed operands to the ALU.
- `INST` out 4: ALU opcode.
- `SEL` out 1: ALU select bit.
- `OUT_DEST` out 3: rd travelling with the op.

## Operation
- Register file: R0 reads 0 always. Writes to R0 are ignored.
- Writeback: a write takes effect at the edge where `WB_EN`=1.
- Scoreboard: 8 pending bits. Bit 0 is always 0.
- Scoreboard set: on accept with rd≠0, set `pend[rd]`.
- Scoreboard clear: on `WB_EN`, clear `pend[WB_ADDR]`.
- Simultaneous set and clear of the same bit: set wins.
- Hazard: `haz` = `pend[ra]` | `pend[rb]`, with the exception defined under Configuration.
- Every opcode checks both ra and rb, including opcodes that ignore B.
- Ready: `IN_READY` = !`haz` && (!`OUT_VALID` || `OUT_READY`). This is combinational from `IN_INSTR`, `WB_*`, and `OUT_READY`.
- Accept: happens when `IN_VALID` && `IN_READY` at a rising edge. At that edge:
  - `A`/`B` load the register-file values of ra/rb.
  - `INST` loads the opcode, `SEL` loads bit 2, `OUT_DEST` loads rd.
  - `OUT_VALID` is set to 1.
- Drain: `OUT_VALID` && `OUT_READY` with no new accept clears `OUT_VALID`. Payload outputs hold their last value.
- Stall: while `OUT_VALID` && !`OUT_READY`, all outputs hold stable.
- No instruction is dropped or duplicated.

## Timing
- Reset values:
  - `OUT_VALID`=0, `A`=`B`=0, `INST`=0, `SEL`=0, `OUT_DEST`=0.
  - All pending bits 0.
  - R1–R7 = `REG_RESET`.
  - `IN_READY`=1 once `RST` deasserts.
- Reset asserted mid-operation discards the held op and all pending bits immediately, without waiting for a clock edge.
- Latency: 1 cycle, accept edge to `OUT_VALID`.
- Throughput: 1 op per cycle when there are no hazards and `OUT_READY`=1.
- Same-edge drain and accept: `OUT_VALID` stays 1 and the new payload loads.
- Dependent op issued back to back: it stalls until the edge where `WB_EN` writes its source. Minimum gap is set by the downstream writeback latency.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined:
  - A same-cycle `WB_EN` to ra or rb suppresses that register's pending bit in `haz`.
  - The operand loads `WB_DATA` instead of the stale file value.
  - A dependent op therefore issues in the writeback cycle.
- `ALU_ISSUE_BYPASS_EN` undefined:
  - No forwarding. A same-cycle write is not visible to the read.
  - The pending bit still blocks, so issue happens on the cycle after writeback.
  - Hazards add exactly one stall cycle relative to the defined case.

## Test plan
- Reset and R0: after reset, issue `{0000,001,000,000,0,00}` → `OUT_VALID`=1 next cycle, `A`=`B`=0, `INST`=0, `OUT_DEST`=1. `WB_EN` to R0 with 32'hDEAD_BEEF, then read R0 → 0.
- Writeback/read: WB R2=32'h0000_0005, R3=32'hFFFF_FFFD, then issue opcode 1000 ra=2 rb=3 sel=1 → `A`=5, `B`=-3, `INST`=4'b1000, `SEL`=1.
- RAW stall: issue rd=4; next op reads ra=4 → `IN_READY`=0. WB R4=32'h0000_0010. With bypass: accept that cycle, `A`=32'h10. Without bypass: accept one cycle later, `A`=32'h10.
- Backpressure: hold `OUT_READY`=0 for 5 cycles with `IN_VALID`=1 → outputs unchanged, `IN_READY`=0. Release → the held op drains and the next op loads on the same edge.
- Simultaneous set/clear: WB R5 in the same cycle an op with rd=5 is accepted → `pend[5]` remains 1, so a following reader of R5 stalls.
- Async reset: assert `RST` mid-stall → `OUT_VALID` drops immediately and all registers return to `REG_RESET`.
